byte_data_memory: RTL and testbench

BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

---
 rtl/byte_data_memory.sv | 165 ++++++++++++++++
 tb/tb_byte_data_memory.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_data_memory.sv
// byte_data_memory: byte-addressable 32-bit-word data memory with
// byte/half/word loads and stores, sign/zero extension of sub-word loads,
// misalignment detection and an optional clear-to-zero sweep after reset.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   address     byte address (little-endian), word index = address[AW-1:2]
//   MemWrite    store request
//   MemRead     load request
//   Size        00 byte, 01 half, 10 word, 11 illegal
//   Unsigned    1 = zero-extend sub-word loads, 0 = sign-extend
//   WriteData   store data, right-aligned
//   ReadData    registered load data (holds when ReadValid is low)
//   ReadValid   one-cycle pulse qualifying ReadData
//   Misaligned  one-cycle pulse flagging a rejected access
//   Busy        high while the clear sweep runs; requests are ignored
//
// state | meaning
// CLEAR | zeroing word clr_cnt each edge, requests ignored
// READY | servicing one request per cycle
module byte_data_memory #(
  parameter int ADDR_WIDTH     = 7,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  ReadValid,
  output logic                  Misaligned,
  output logic                  Busy
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;
  logic              misaligned_q, misaligned_d;

  logic [31:0]       mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_ext;
  logic              mis_cond;

  logic              mem_we;
  logic [3:0]        mem_be;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       mem_wdata;

  assign idx      = address[ADDR_WIDTH-1:2];
  // Combinational array read before the edge gives read-first behaviour
  // when a load and a store hit the same word in one cycle.
  assign rd_word  = mem[idx];
  assign rd_byte  = rd_word[8*address[1:0] +: 8];
  assign rd_half  = address[1] ? rd_word[31:16] : rd_word[15:0];
  assign mis_cond = (Size == 2'b01 && address[0]) ||
                    (Size == 2'b10 && address[1:0] != 2'b00) ||
                    (Size == 2'b11);

  always_comb begin
    load_ext = rd_word;
    case (Size)
      2'b00:   load_ext = Unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = Unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_ext = rd_word;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    misaligned_d = 1'b0;
    mem_we       = 1'b0;
    mem_be       = 4'h0;
    mem_idx      = idx;
    mem_wdata    = 32'h0;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_be    = 4'hF;
        mem_idx   = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) state_d = READY;
      end
      READY: begin
        if ((MemRead || MemWrite) && mis_cond) begin
          misaligned_d = 1'b1;
        end else begin
          if (MemWrite) begin
            mem_we = 1'b1;
            case (Size)
              2'b00: begin
                mem_be    = 4'b0001 << address[1:0];
                mem_wdata = {4{WriteData[7:0]}};
              end
              2'b01: begin
                mem_be    = address[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{WriteData[15:0]}};
              end
              default: begin
                mem_be    = 4'hF;
                mem_wdata = WriteData;
              end
            endcase
          end
          if (MemRead) begin
            read_valid_d = 1'b1;
            read_data_d  = load_ext;
          end
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_cnt_q    <= '0;
      read_data_q  <= 32'h0;
      read_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Array has no reset; writes are blocked while reset is held so that
  // contents persist across reset when no clear sweep is configured.
  always_ff @(posedge clock) begin
    if (mem_we && reset_n) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign ReadData   = read_data_q;
  assign ReadValid  = read_valid_q;
  assign Misaligned = misaligned_q;
  assign Busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_byte_data_memory.sv
module tb_byte_data_memory;

  logic        clock;
  logic        reset_n;
  logic [6:0]  address;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        ReadValid;
  logic        Misaligned;
  logic        Busy;

  int n_vec  = 0;
  int n_fail = 0;

  byte_data_memory dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .address    (address),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Size       (Size),
    .Unsigned   (Unsigned),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .ReadValid  (ReadValid),
    .Misaligned (Misaligned),
    .Busy       (Busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic        re;
    logic [1:0]  sz;
    logic        uns;
    logic [6:0]  addr;
    logic [31:0] wd;
    logic        ev;
    logic        em;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic we, input logic re, input logic [1:0] sz,
                     input logic uns, input logic [6:0] addr, input logic [31:0] wd,
                     input logic ev, input logic em, input logic [31:0] ed);
    vec_t v;
    v.we = we; v.re = re; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
    v.ev = ev; v.em = em; v.ed = ed;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [1:0] sz,
                       input logic uns, input logic [6:0] addr, input logic [31:0] wd);
    MemWrite = we; MemRead = re; Size = sz; Unsigned = uns; address = addr; WriteData = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 7'd0, 32'h0);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Counts edges from reset release until Busy drops, checking that requests
  // applied during the sweep produce no pulses. Writes to word 0 are aimed at
  // late in the sweep so a leaked write would survive the clear.
  task automatic count_clear(input string tag);
    int n;
    n = 0;
    chk({tag, " busy at release"}, 32'(Busy), 32'd1);
    while (Busy && n < 40) begin
      drive(1'b1, 1'b1, (n % 2 == 1) ? 2'b11 : 2'b10, 1'b0, 7'd0, 32'hFFFF_FFFF);
      cyc();
      n++;
      if (ReadValid !== 1'b0 || Misaligned !== 1'b0) begin
        chk({tag, " pulses during clear"}, {30'h0, ReadValid, Misaligned}, 32'h0);
      end
    end
    idle();
    chk({tag, " clear edge count"}, 32'(n), 32'd32);
    chk({tag, " busy after clear"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    idle();

    // Table of single-cycle vectors applied after the initial clear.
    //   we    re    sz     uns   addr   wdata          ev    em    expected ReadData
    add(1'b1, 1'b0, 2'b10, 1'b0, 7'd4,  32'h800000FF, 1'b0, 1'b0, 32'h00000000);
    add(1'b0, 1'b1, 2'b00, 1'b0, 7'd4,  32'h0,        1'b1, 1'b0, 32'hFFFFFFFF);
    add(1'b0, 1'b1, 2'b00, 1'b1, 7'd4,  32'h0,        1'b1, 1'b0, 32'h000000FF);
    add(1'b0, 1'b1, 2'b10, 1'b0, 7'd4,  32'h0,        1'b1, 1'b0, 32'h800000FF);
    add(1'b0, 1'b1, 2'b01, 1'b0, 7'd6,  32'h0,        1'b1, 1'b0, 32'hFFFF8000);
    add(1'b0, 1'b1, 2'b01, 1'b1, 7'd6,  32'h0,        1'b1, 1'b0, 32'h00008000);
    add(1'b1, 1'b0, 2'b00, 1'b0, 7'd5,  32'h0000005A, 1'b0, 1'b0, 32'h00008000);
    add(1'b0, 1'b1, 2'b10, 1'b0, 7'd4,  32'h0,        1'b1, 1'b0, 32'h80005AFF);
    add(1'b1, 1'b0, 2'b10, 1'b0, 7'd2,  32'hDEADBEEF, 1'b0, 1'b1, 32'h80005AFF);
    add(1'b0, 1'b1, 2'b01, 1'b0, 7'd1,  32'h0,        1'b0, 1'b1, 32'h80005AFF);
    add(1'b0, 1'b1, 2'b11, 1'b0, 7'd0,  32'h0,        1'b0, 1'b1, 32'h80005AFF);
    add(1'b1, 1'b1, 2'b11, 1'b0, 7'd4,  32'h12345678, 1'b0, 1'b1, 32'h80005AFF);
    add(1'b0, 1'b1, 2'b10, 1'b0, 7'd0,  32'h0,        1'b1, 1'b0, 32'h00000000);
    add(1'b0, 1'b1, 2'b10, 1'b0, 7'd4,  32'h0,        1'b1, 1'b0, 32'h80005AFF);
    add(1'b1, 1'b1, 2'b10, 1'b0, 7'd8,  32'h0000002A, 1'b1, 1'b0, 32'h00000000);
    add(1'b0, 1'b1, 2'b10, 1'b0, 7'd8,  32'h0,        1'b1, 1'b0, 32'h0000002A);
    add(1'b1, 1'b0, 2'b01, 1'b0, 7'd10, 32'h1234BEEF, 1'b0, 1'b0, 32'h0000002A);
    add(1'b0, 1'b1, 2'b10, 1'b0, 7'd8,  32'h0,        1'b1, 1'b0, 32'hBEEF002A);
    add(1'b0, 1'b1, 2'b00, 1'b0, 7'd11, 32'h0,        1'b1, 1'b0, 32'hFFFFFFBE);
    add(1'b0, 1'b1, 2'b00, 1'b1, 7'd10, 32'h0,        1'b1, 1'b0, 32'h000000EF);
    add(1'b0, 1'b1, 2'b01, 1'b0, 7'd8,  32'h0,        1'b1, 1'b0, 32'h0000002A);
    add(1'b1, 1'b0, 2'b00, 1'b0, 7'd3,  32'hAAAAAA80, 1'b0, 1'b0, 32'h0000002A);
    add(1'b0, 1'b1, 2'b10, 1'b0, 7'd0,  32'h0,        1'b1, 1'b0, 32'h80000000);

    // Reset values, held across clock edges.
    #1;
    chk("reset ReadData", ReadData, 32'h0);
    chk("reset ReadValid", 32'(ReadValid), 32'd0);
    chk("reset Misaligned", 32'(Misaligned), 32'd0);
    chk("reset Busy", 32'(Busy), 32'd1);
    cyc(); cyc();
    chk("reset Busy held", 32'(Busy), 32'd1);

    @(negedge clock);
    reset_n = 1'b1;
    #1;
    count_clear("init");

    // Every word reads back zero after the sweep.
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b1, 2'b10, 1'b0, 7'(a * 4), 32'h0);
      cyc();
      chk($sformatf("sweep rv a%0d", a * 4), 32'(ReadValid), 32'd1);
      chk($sformatf("sweep data a%0d", a * 4), ReadData, 32'h0);
    end
    idle();

    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].re, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd);
      cyc();
      chk($sformatf("v%0d ReadValid", i), 32'(ReadValid), 32'(tbl[i].ev));
      chk($sformatf("v%0d Misaligned", i), 32'(Misaligned), 32'(tbl[i].em));
      chk($sformatf("v%0d ReadData", i), ReadData, tbl[i].ed);
    end
    idle();
    cyc();
    chk("idle ReadValid", 32'(ReadValid), 32'd0);
    chk("idle Misaligned", 32'(Misaligned), 32'd0);
    chk("idle ReadData hold", ReadData, 32'h80000000);

    // Read pulse then asynchronous reset mid-cycle clears outputs at once.
    drive(1'b0, 1'b1, 2'b10, 1'b0, 7'd8, 32'h0);
    cyc();
    idle();
    chk("pre-reset ReadValid", 32'(ReadValid), 32'd1);
    chk("pre-reset ReadData", ReadData, 32'hBEEF002A);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async ReadValid", 32'(ReadValid), 32'd0);
    chk("async ReadData", ReadData, 32'h0);
    chk("async Busy", 32'(Busy), 32'd1);

    // Abort a sweep at clear cycle 10; the next sweep must restart at word 0.
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) cyc();
    chk("mid-clear Busy", 32'(Busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid-clear reset Busy", 32'(Busy), 32'd1);
    chk("mid-clear reset ReadData", ReadData, 32'h0);
    chk("mid-clear reset ReadValid", 32'(ReadValid), 32'd0);
    chk("mid-clear reset Misaligned", 32'(Misaligned), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    count_clear("restart");

    drive(1'b0, 1'b1, 2'b10, 1'b0, 7'd8, 32'h0);
    cyc();
    chk("post-clear rv a8", 32'(ReadValid), 32'd1);
    chk("post-clear data a8", ReadData, 32'h0);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 7'd4, 32'h0);
    cyc();
    chk("post-clear data a4", ReadData, 32'h0);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 7'd0, 32'h0);
    cyc();
    chk("post-clear data a0", ReadData, 32'h0);
    idle();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
